reg_commit_stage: RTL and testbench

- In-order commit/writeback unit for the out-of-order core.
- Dispatch allocates a tagged entry per instruction. Execute units return results out of order by tag.
- Results retire strictly in program order, at most one per cycle. Each retirement drives the register-file write side (regWrite, writeAddr, WriteData).
- Sits between the execute/completion bus and the register read/write stage. It is the producer of the register-file write port.

---
 rtl/reg_commit_stage_if.sv | 30 +++
 rtl/reg_commit_stage.sv | 100 ++++++++++
 tb/tb_reg_commit_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_commit_stage_if.sv
// Dispatch, completion and register-file write bundle for reg_commit_stage.
// master = dispatch/execute/regfile side, slave = commit stage.
interface reg_commit_stage_if #(
    parameter int TAG_W = 3
);
    logic              allocValid;
    logic [4:0]        allocDest;
    logic              allocWritesReg;
    logic              allocReady;
    logic [TAG_W-1:0]  allocTag;
    logic              compValid;
    logic [TAG_W-1:0]  compTag;
    logic [63:0]       compData;
    logic              flush;
    logic              regWrite;
    logic [4:0]        writeAddr;
    logic [63:0]       WriteData;
    logic [TAG_W:0]    count;
    logic              empty;

    modport master (
        output allocValid, allocDest, allocWritesReg, compValid, compTag, compData, flush,
        input  allocReady, allocTag, regWrite, writeAddr, WriteData, count, empty
    );

    modport slave (
        input  allocValid, allocDest, allocWritesReg, compValid, compTag, compData, flush,
        output allocReady, allocTag, regWrite, writeAddr, WriteData, count, empty
    );
endinterface

// File: rtl/reg_commit_stage.sv
// In-order commit stage: tagged entries are allocated at dispatch, completed out of
// order by tag, and retired one per cycle in program order onto the register-file write port.
module reg_commit_stage #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    reg_commit_stage_if.slave bus
);
    localparam logic [TAG_W:0]   CNT_ZERO = (TAG_W+1)'(0);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] PTR_ZERO = TAG_W'(0);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_wr;
    logic [4:0]       r_dest [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;
    logic             r_reg_write;
    logic [4:0]       r_write_addr;
    logic [63:0]      r_write_data;

    logic w_alloc_ready;
    logic w_alloc;
    logic w_comp;
    logic w_commit;

    assign w_alloc_ready = (r_count != CNT_FULL);
    assign w_alloc       = bus.allocValid && w_alloc_ready;
    assign w_comp        = bus.compValid && r_valid[bus.compTag];
    // Only flags registered in earlier cycles qualify, so a completion to the head retires next cycle.
    assign w_commit      = r_valid[r_head] && r_done[r_head];

    assign bus.allocReady = w_alloc_ready;
    assign bus.allocTag   = r_tail;
    assign bus.regWrite   = r_reg_write;
    assign bus.writeAddr  = r_write_addr;
    assign bus.WriteData  = r_write_data;
    assign bus.count      = r_count;
    assign bus.empty      = (r_count == CNT_ZERO);

    // Entry table, pointers, occupancy count and registered register-file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_wr         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dest[i] <= 5'd0;
                r_data[i] <= 64'd0;
            end
            r_head       <= PTR_ZERO;
            r_tail       <= PTR_ZERO;
            r_count      <= CNT_ZERO;
            r_reg_write  <= 1'b0;
            r_write_addr <= 5'd0;
            r_write_data <= 64'd0;
        end else if (bus.flush) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_head      <= PTR_ZERO;
            r_tail      <= PTR_ZERO;
            r_count     <= CNT_ZERO;
            r_reg_write <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            if (w_comp) begin
                r_done[bus.compTag] <= 1'b1;
                r_data[bus.compTag] <= bus.compData;
            end
            // Commit is ordered after completion so a retiring entry is always cleared.
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + PTR_ONE;
                r_reg_write     <= r_wr[r_head] && (r_dest[r_head] != 5'd31);
                r_write_addr    <= r_dest[r_head];
                r_write_data    <= r_data[r_head];
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_wr[r_tail]    <= bus.allocWritesReg;
                r_dest[r_tail]  <= bus.allocDest;
                r_tail          <= r_tail + PTR_ONE;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_commit_stage.sv
// Directed self-checking bench for reg_commit_stage with hand-computed expectations.
module tb_reg_commit_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    reg_commit_stage_if #(.TAG_W(3)) bus ();

    reg_commit_stage #(.DEPTH(8), .TAG_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.allocValid     = 1'b0;
        bus.allocDest      = 5'd0;
        bus.allocWritesReg = 1'b0;
        bus.compValid      = 1'b0;
        bus.compTag        = 3'd0;
        bus.compData       = 64'd0;
        bus.flush          = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] dest, input logic wr);
        bus.allocValid     = 1'b1;
        bus.allocDest      = dest;
        bus.allocWritesReg = wr;
        tick();
        bus.allocValid     = 1'b0;
    endtask

    task automatic comp(input logic [2:0] tag, input logic [63:0] data);
        bus.compValid = 1'b1;
        bus.compTag   = tag;
        bus.compData  = data;
        tick();
        bus.compValid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        reset = 1'b1;
        #12;
        chk("rst_regWrite", {63'd0, bus.regWrite}, 64'd0);
        chk("rst_writeAddr", {59'd0, bus.writeAddr}, 64'd0);
        chk("rst_WriteData", bus.WriteData, 64'd0);
        chk("rst_allocTag", {61'd0, bus.allocTag}, 64'd0);
        chk("rst_allocReady", {63'd0, bus.allocReady}, 64'd1);
        chk("rst_empty", {63'd0, bus.empty}, 64'd1);
        chk("rst_count", {60'd0, bus.count}, 64'd0);
        tick();
        reset = 1'b0;

        // Single entry: completion in cycle N, write visible in cycle N+2 only.
        alloc(5'd5, 1'b1);
        chk("t1_count", {60'd0, bus.count}, 64'd1);
        chk("t1_allocTag", {61'd0, bus.allocTag}, 64'd1);
        comp(3'd0, 64'hDEAD_BEEF);
        chk("t1_n1_regWrite", {63'd0, bus.regWrite}, 64'd0);
        tick();
        chk("t1_n2_regWrite", {63'd0, bus.regWrite}, 64'd1);
        chk("t1_writeAddr", {59'd0, bus.writeAddr}, 64'd5);
        chk("t1_WriteData", bus.WriteData, 64'hDEAD_BEEF);
        chk("t1_empty", {63'd0, bus.empty}, 64'd1);
        tick();
        chk("t1_n3_regWrite", {63'd0, bus.regWrite}, 64'd0);
        chk("t1_hold_addr", {59'd0, bus.writeAddr}, 64'd5);

        // Out-of-order completion, in-order retirement.
        do_flush();
        chk("t2_flush_tag", {61'd0, bus.allocTag}, 64'd0);
        for (int i = 1; i <= 3; i++) alloc(5'(i), 1'b1);
        chk("t2_count", {60'd0, bus.count}, 64'd3);
        comp(3'd2, 64'h22);
        chk("t2_no_early_a", {63'd0, bus.regWrite}, 64'd0);
        comp(3'd0, 64'h00);
        chk("t2_no_early_b", {63'd0, bus.regWrite}, 64'd0);
        comp(3'd1, 64'h11);
        chk("t2_w1_en", {63'd0, bus.regWrite}, 64'd1);
        chk("t2_w1_addr", {59'd0, bus.writeAddr}, 64'd1);
        chk("t2_w1_data", bus.WriteData, 64'h00);
        tick();
        chk("t2_w2_en", {63'd0, bus.regWrite}, 64'd1);
        chk("t2_w2_addr", {59'd0, bus.writeAddr}, 64'd2);
        chk("t2_w2_data", bus.WriteData, 64'h11);
        tick();
        chk("t2_w3_en", {63'd0, bus.regWrite}, 64'd1);
        chk("t2_w3_addr", {59'd0, bus.writeAddr}, 64'd3);
        chk("t2_w3_data", bus.WriteData, 64'h22);
        tick();
        chk("t2_idle_en", {63'd0, bus.regWrite}, 64'd0);
        chk("t2_empty", {63'd0, bus.empty}, 64'd1);

        // Fill, blocked allocation, wrap of the tail.
        do_flush();
        for (int i = 0; i < 8; i++) alloc(5'(i + 8), 1'b1);
        chk("t3_full_ready", {63'd0, bus.allocReady}, 64'd0);
        chk("t3_full_count", {60'd0, bus.count}, 64'd8);
        chk("t3_wrap_tag", {61'd0, bus.allocTag}, 64'd0);
        alloc(5'd20, 1'b1);
        chk("t3_ninth_count", {60'd0, bus.count}, 64'd8);
        chk("t3_ninth_tag", {61'd0, bus.allocTag}, 64'd0);
        comp(3'd0, 64'h77);
        chk("t3_pre_ready", {63'd0, bus.allocReady}, 64'd0);
        tick();
        chk("t3_commit_en", {63'd0, bus.regWrite}, 64'd1);
        chk("t3_commit_addr", {59'd0, bus.writeAddr}, 64'd8);
        chk("t3_commit_data", bus.WriteData, 64'h77);
        chk("t3_post_ready", {63'd0, bus.allocReady}, 64'd1);
        chk("t3_post_count", {60'd0, bus.count}, 64'd7);
        alloc(5'd30, 1'b1);
        chk("t3_realloc_tag", {61'd0, bus.allocTag}, 64'd1);
        chk("t3_realloc_count", {60'd0, bus.count}, 64'd8);

        // Zero register and non-writing instructions retire without a write.
        do_flush();
        alloc(5'd31, 1'b1);
        alloc(5'd4, 1'b0);
        comp(3'd0, 64'hAA);
        comp(3'd1, 64'hBB);
        chk("t4_x31_en", {63'd0, bus.regWrite}, 64'd0);
        chk("t4_x31_count", {60'd0, bus.count}, 64'd1);
        tick();
        chk("t4_nowr_en", {63'd0, bus.regWrite}, 64'd0);
        chk("t4_nowr_count", {60'd0, bus.count}, 64'd0);
        chk("t4_nowr_addr", {59'd0, bus.writeAddr}, 64'd4);

        // Flush coinciding with a pending head commit.
        do_flush();
        for (int i = 0; i < 4; i++) alloc(5'(i + 10), 1'b1);
        comp(3'd0, 64'h100);
        comp(3'd1, 64'h101);
        chk("t5_pre_en", {63'd0, bus.regWrite}, 64'd1);
        chk("t5_pre_addr", {59'd0, bus.writeAddr}, 64'd10);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t5_flush_en", {63'd0, bus.regWrite}, 64'd0);
        chk("t5_flush_count", {60'd0, bus.count}, 64'd0);
        chk("t5_flush_tag", {61'd0, bus.allocTag}, 64'd0);
        chk("t5_flush_addr", {59'd0, bus.writeAddr}, 64'd10);
        comp(3'd1, 64'h999);
        for (int i = 0; i < 3; i++) begin
            chk("t5_stale_en", {63'd0, bus.regWrite}, 64'd0);
            chk("t5_stale_count", {60'd0, bus.count}, 64'd0);
            tick();
        end

        // Asynchronous reset with three done entries pending.
        alloc(5'd20, 1'b1);
        alloc(5'd21, 1'b1);
        alloc(5'd22, 1'b1);
        comp(3'd2, 64'h2);
        comp(3'd1, 64'h1);
        comp(3'd0, 64'h5);
        chk("t6_pre_count", {60'd0, bus.count}, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_en", {63'd0, bus.regWrite}, 64'd0);
        chk("t6_rst_addr", {59'd0, bus.writeAddr}, 64'd0);
        chk("t6_rst_data", bus.WriteData, 64'd0);
        chk("t6_rst_count", {60'd0, bus.count}, 64'd0);
        chk("t6_rst_tag", {61'd0, bus.allocTag}, 64'd0);
        chk("t6_rst_empty", {63'd0, bus.empty}, 64'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_after_en", {63'd0, bus.regWrite}, 64'd0);
            chk("t6_after_addr", {59'd0, bus.writeAddr}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
